// File: rtl/tunable_clock_gen.sv
// ---------------------------------------------------------------------------
// tunable_clock_gen
//
// Generates a square-wave clock whose half-period is a programmable divisor
// of the system clock. The divisor can be nudged up or down at run time with
// single-cycle request pulses. Every value is kept inside a window built from
// the fmax/fmin bounds.
//
// Ports
//   clk_frequency  in   system clock, rising-edge logic
//   rst_frequency  in   asynchronous active-low reset
//   init           in   level enable: 1 = run, 0 = idle
//   setperiod[7:0] in   half-period divisor loaded on entry to RUN
//   fmax[7:0]      in   lower divisor bound (highest output frequency)
//   fmin[7:0]      in   upper divisor bound (lowest output frequency)
//   increment      in   one-cycle request: divisor + STEP
//   decrement      in   one-cycle request: divisor - STEP
//   gen_clk        out  generated clock (registered)
//   current_div    out  active half-period divisor
//   limit_hi       out  current_div sits on the effective upper bound
//   limit_lo       out  current_div sits on the effective lower bound
//   update_done    out  one-cycle pulse when current_div changes at a boundary
// ---------------------------------------------------------------------------
module tunable_clock_gen #(
    parameter int unsigned STEP = 1
) (
    input  logic       clk_frequency,
    input  logic       rst_frequency,
    input  logic       init,
    input  logic [7:0] setperiod,
    input  logic [7:0] fmax,
    input  logic [7:0] fmin,
    input  logic       increment,
    input  logic       decrement,
    output logic       gen_clk,
    output logic [7:0] current_div,
    output logic       limit_hi,
    output logic       limit_lo,
    output logic       update_done
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    typedef enum logic [1:0] {
        PEND_NONE,
        PEND_UP,
        PEND_DOWN
    } pend_t;

    localparam logic [8:0] STEP9 = 9'(STEP);

    state_t     state, state_next;
    pend_t      pend, pend_next;
    logic [7:0] count, count_next;
    logic [7:0] div_next;
    logic       gen_next;
    logic       done_next;

    logic [7:0] lo;
    logic [7:0] hi;
    logic       boundary;
    logic       req_valid;
    pend_t      req;
    logic [9:0] up_wide;
    logic [8:0] up_sat;
    logic [8:0] down_sat;
    logic [7:0] adjusted;

    function automatic logic [7:0] clamp_div(input logic [8:0] value,
                                             input logic [7:0] low,
                                             input logic [7:0] high);
        if (value < {1'b0, low}) begin
            return low;
        end else if (value > {1'b0, high}) begin
            return high;
        end else begin
            return value[7:0];
        end
    endfunction

    // A zero lower bound would stall the counter, so it is forced to 1.
    // An inverted window collapses onto the lower bound.
    assign lo = (fmax == 8'd0) ? 8'd1 : fmax;
    assign hi = (fmin < lo) ? lo : fmin;

    assign limit_hi = (current_div == hi);
    assign limit_lo = (current_div == lo);

    // current_div is never below 1 in RUN, so current_div - 1 cannot wrap here
    assign boundary = (state == RUN) && (count == current_div - 8'd1);

    // Simultaneous increment and decrement cancel and leave pending untouched
    assign req_valid = increment ^ decrement;
    assign req       = increment ? PEND_UP : PEND_DOWN;

    // Saturating adjustment; the final clamp also re-fits the divisor when
    // the bounds have moved since it was last set
    assign up_wide  = {2'b00, current_div} + {1'b0, STEP9};
    assign up_sat   = up_wide[9] ? 9'h1FF : up_wide[8:0];
    assign down_sat = ({1'b0, current_div} >= STEP9) ? ({1'b0, current_div} - STEP9) : 9'd0;

    always_comb begin
        adjusted = clamp_div({1'b0, current_div}, lo, hi);
        if (pend == PEND_UP) begin
            adjusted = clamp_div(up_sat, lo, hi);
        end else if (pend == PEND_DOWN) begin
            adjusted = clamp_div(down_sat, lo, hi);
        end
    end

    always_ff @(posedge clk_frequency or negedge rst_frequency) begin
        if (!rst_frequency) begin
            state       <= IDLE;
            pend        <= PEND_NONE;
            count       <= 8'd0;
            gen_clk     <= 1'b0;
            current_div <= 8'd0;
            update_done <= 1'b0;
        end else begin
            state       <= state_next;
            pend        <= pend_next;
            count       <= count_next;
            gen_clk     <= gen_next;
            current_div <= div_next;
            update_done <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        pend_next  = pend;
        count_next = count;
        gen_next   = gen_clk;
        div_next   = current_div;
        done_next  = 1'b0;

        if (state == IDLE) begin
            count_next = 8'd0;
            gen_next   = 1'b0;
            pend_next  = PEND_NONE;
            if (init) begin
                state_next = RUN;
                div_next   = clamp_div({1'b0, setperiod}, lo, hi);
            end
        end else if (!init) begin
            state_next = IDLE;
            count_next = 8'd0;
            gen_next   = 1'b0;
            pend_next  = PEND_NONE;
        end else begin
            // A request landing on the boundary cycle is latched, not applied;
            // it survives the clear and waits for the following boundary
            if (req_valid) begin
                pend_next = req;
            end else if (boundary) begin
                pend_next = PEND_NONE;
            end

            if (boundary) begin
                count_next = 8'd0;
                gen_next   = ~gen_clk;
                div_next   = adjusted;
                done_next  = (adjusted != current_div);
            end else begin
                count_next = count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_tunable_clock_gen.sv
// ---------------------------------------------------------------------------
// tb_tunable_clock_gen
//
// Directed bench for tunable_clock_gen. Inputs change and outputs are sampled
// 1 ns after each rising clock edge. Expected values are hand-derived
// constants.
// ---------------------------------------------------------------------------
module tb_tunable_clock_gen;

    logic       clk_frequency;
    logic       rst_frequency;
    logic       init;
    logic [7:0] setperiod;
    logic [7:0] fmax;
    logic [7:0] fmin;
    logic       increment;
    logic       decrement;
    logic       gen_clk;
    logic [7:0] current_div;
    logic       limit_hi;
    logic       limit_lo;
    logic       update_done;

    int compareCount;
    int mismatchCount;
    int halfLen;

    tunable_clock_gen #(.STEP(1)) dut (
        .clk_frequency(clk_frequency),
        .rst_frequency(rst_frequency),
        .init(init),
        .setperiod(setperiod),
        .fmax(fmax),
        .fmin(fmin),
        .increment(increment),
        .decrement(decrement),
        .gen_clk(gen_clk),
        .current_div(current_div),
        .limit_hi(limit_hi),
        .limit_lo(limit_lo),
        .update_done(update_done)
    );

    initial clk_frequency = 1'b0;
    always #5 clk_frequency = ~clk_frequency;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk_frequency);
        #1;
    endtask

    // One cycle with the given request inputs, then both requests drop
    task automatic applyStimulus(input logic inc, input logic dec);
        increment = inc;
        decrement = dec;
        tick();
        increment = 1'b0;
        decrement = 1'b0;
    endtask

    // Cycles until gen_clk next changes level, bounded
    task automatic measureHalf(output int n);
        logic startLevel;
        startLevel = gen_clk;
        n = 0;
        do begin
            tick();
            n++;
        end while (gen_clk == startLevel && n < 2000);
        if (gen_clk == startLevel) begin
            compareCount++;
            mismatchCount++;
            $display("[TB] FAIL halfTimeout: got no toggle in %0d cycles, expected one", n);
        end
    endtask

    initial begin
        compareCount  = 0;
        mismatchCount = 0;
        rst_frequency = 1'b0;
        init          = 1'b0;
        setperiod     = 8'd125;
        fmax          = 8'd90;
        fmin          = 8'd160;
        increment     = 1'b0;
        decrement     = 1'b0;

        // Reset state
        #3;
        checkOutput("rstGen", gen_clk, 0);
        checkOutput("rstDiv", current_div, 0);
        checkOutput("rstDone", update_done, 0);
        checkOutput("rstLimHi", limit_hi, 0);
        checkOutput("rstLimLo", limit_lo, 0);
        tick();
        rst_frequency = 1'b1;
        tick();
        tick();
        checkOutput("idleDiv", current_div, 0);

        // Basic run at 125
        init = 1'b1;
        tick();
        checkOutput("runDiv", current_div, 125);
        checkOutput("runGen", gen_clk, 0);
        measureHalf(halfLen);
        checkOutput("firstHalf", halfLen, 125);
        checkOutput("firstGen", gen_clk, 1);
        measureHalf(halfLen);
        checkOutput("secondHalf", halfLen, 125);

        // Single increment applied at next boundary
        applyStimulus(1'b1, 1'b0);
        measureHalf(halfLen);
        checkOutput("incHalf", halfLen + 1, 125);
        checkOutput("incDiv", current_div, 126);
        checkOutput("incDone", update_done, 1);
        tick();
        checkOutput("incDonePulse", update_done, 0);
        measureHalf(halfLen);
        checkOutput("incNewHalf", halfLen + 1, 126);
        measureHalf(halfLen);
        checkOutput("incNewHalf2", halfLen, 126);
        checkOutput("preIdleGen", gen_clk, 1);

        // init low drops gen_clk on the next edge; divisor retained
        init = 1'b0;
        tick();
        checkOutput("idleGen", gen_clk, 0);
        checkOutput("idleKeepDiv", current_div, 126);

        // Upper saturation
        setperiod = 8'd160;
        init      = 1'b1;
        tick();
        checkOutput("hiDiv", current_div, 160);
        checkOutput("hiLimHi", limit_hi, 1);
        checkOutput("hiLimLo", limit_lo, 0);
        applyStimulus(1'b1, 1'b0);
        measureHalf(halfLen);
        checkOutput("hiHalf", halfLen + 1, 160);
        checkOutput("hiSatDiv", current_div, 160);
        checkOutput("hiSatDone", update_done, 0);
        checkOutput("hiSatLim", limit_hi, 1);

        // Lower clamp on load
        init = 1'b0;
        tick();
        setperiod = 8'd50;
        init      = 1'b1;
        tick();
        checkOutput("loDiv", current_div, 90);
        checkOutput("loLimLo", limit_lo, 1);
        checkOutput("loLimHi", limit_hi, 0);

        // Simultaneous requests are ignored
        init = 1'b0;
        tick();
        setperiod = 8'd100;
        init      = 1'b1;
        tick();
        checkOutput("midDiv", current_div, 100);
        applyStimulus(1'b1, 1'b1);
        measureHalf(halfLen);
        checkOutput("bothHalf", halfLen + 1, 100);
        checkOutput("bothDiv", current_div, 100);
        checkOutput("bothDone", update_done, 0);

        // Last request wins within a half-period
        applyStimulus(1'b1, 1'b0);
        tick();
        tick();
        tick();
        applyStimulus(1'b0, 1'b1);
        measureHalf(halfLen);
        checkOutput("lastWinsHalf", halfLen + 5, 100);
        checkOutput("lastWinsDiv", current_div, 99);
        checkOutput("lastWinsDone", update_done, 1);

        // Request on the boundary cycle is deferred one half-period
        repeat (98) tick();
        increment = 1'b1;
        tick();
        increment = 1'b0;
        checkOutput("bndGen", gen_clk, 1);
        checkOutput("bndDiv", current_div, 99);
        checkOutput("bndDone", update_done, 0);
        measureHalf(halfLen);
        checkOutput("bndHalf", halfLen, 99);
        checkOutput("bndLaterDiv", current_div, 100);
        checkOutput("bndLaterDone", update_done, 1);

        // Asynchronous reset mid half-period with a pending request
        measureHalf(halfLen);
        checkOutput("preRstHalf", halfLen, 100);
        repeat (10) tick();
        applyStimulus(1'b1, 1'b0);
        repeat (10) tick();
        #2;
        rst_frequency = 1'b0;
        #1;
        checkOutput("asyncGen", gen_clk, 0);
        checkOutput("asyncDiv", current_div, 0);
        checkOutput("asyncDone", update_done, 0);
        checkOutput("asyncLimHi", limit_hi, 0);
        init = 1'b0;
        tick();
        rst_frequency = 1'b1;
        tick();
        tick();
        tick();
        checkOutput("postRstIdle", current_div, 0);
        checkOutput("postRstGen", gen_clk, 0);

        // Restart reloads setperiod, no carried-over request
        setperiod = 8'd125;
        init      = 1'b1;
        tick();
        checkOutput("restartDiv", current_div, 125);
        measureHalf(halfLen);
        checkOutput("restartHalf", halfLen, 125);
        checkOutput("restartKeepDiv", current_div, 125);
        checkOutput("restartNoDone", update_done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
